// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder controller.
//
// Sequences a single 1-bit full adder over two WIDTH-bit operands, LSB first,
// one bit per clock, with a carry flip-flop between bits. A start/done
// handshake lets ALU-side logic share the one adder.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   : adds the 'sub' input; sub=1 computes a-b (b inverted, carry-in 1)
//   undefined : add only, no 'sub' port
//
// Ports:
//   clock     in   1      rising-edge clock
//   reset_n   in   1      asynchronous active-low reset
//   start     in   1      request, accepted only while idle
//   a, b      in   WIDTH  operands, sampled on the accepting edge
//   cin       in   1      carry-in, sampled on the accepting edge
//   sub       in   1      (SERIAL_ADDER_SUB_EN only) subtract select
//   busy      out  1      high whenever the controller is not idle
//   done      out  1      one-cycle pulse, result valid
//   sum       out  WIDTH  result, held until the next result
//   cout      out  1      carry out of the MSB (1 = no borrow when subtracting)
//   overflow  out  1      signed overflow: carry into MSB ^ carry out of MSB
//
// State table:
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | one operand bit per clock through the full adder
//   S_DONE | result presented, done high for this one cycle

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    full_adder u_fa (
        .a  (a_r[0]),
        .b  (b_r[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Operand B and carry-in as loaded on the accepting edge.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_r <= {fa_s, sum_r[WIDTH-1:1]};
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // On the MSB edge 'carry' holds the carry into the MSB
                        // and fa_co is the carry out, so overflow is formed here.
                        sum      <= {fa_s, sum_r[WIDTH-1:1]};
                        cout     <= fa_co;
                        overflow <= carry ^ fa_co;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
